mem_arbiter_nch: RTL and testbench
==================================

Name: mem_arbiter_nch

Overview:
- Parametrised, N-channel successor to the hard-wired IF/SLB memory mux in the CPU top.
- Accepts 1/2/4-byte read/write requests from N_CH requesters and serialises them onto the single byte-wide RAM/IO port.
- Arbitrates fixed-priority or round-robin; stalls IO accesses while the UART buffer is full.
- Supports flushing of in-flight reads on a control hazard.

Parameters:
- N_CH, 2, number of requester channels (>=2); channel 0 highest priority in fixed mode.
- ADDR_W, 32, address width.
- PRIO_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin.

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  reset, asynchronous, active-low.
- rdy_in  input  1  global ready; low freezes the arbiter.
- flush_in  input  1  control hazard; aborts in-flight read.
- req_valid  input  N_CH  per-channel request.
- req_wr  input  N_CH  1 = write.
- req_size  input  2*N_CH  per channel: 00 byte, 01 half, 10 word (11 treated as word).
- req_addr  input  ADDR_W*N_CH  per-channel start address.
- req_wdata  input  32*N_CH  write data, little-endian.
- req_grant  output  N_CH  one-hot, one-cycle pulse when a request is accepted.
- resp_valid  output  N_CH  one-hot, one-cycle completion pulse.
- resp_rdata  output  32  read data, zero-extended, valid with resp_valid.
- mem_din  input  8  RAM/IO read byte, valid the cycle after its address.
- mem_dout  output  8  write byte.
- mem_a  output  32  byte address (ADDR_W zero-extended).
- mem_wr  output  1  write strobe.
- io_buffer_full  input  1  UART buffer full.
- busy  output  1  high when not IDLE.

Behaviour:
- Reset (rst_in=0, async):
  - State IDLE.
  - mem_a, mem_dout, mem_wr, req_grant, resp_valid, resp_rdata, busy all 0.
  - RR pointer = N_CH-1, so channel 0 is first.
- States: IDLE, RD_ISSUE, RD_TAIL, WR_ISSUE, DONE.
- Grant, in IDLE only, when rdy_in=1, flush_in=0 and any req_valid:
  - Fixed mode: lowest set index wins.
  - RR mode: search starts at pointer+1 mod N_CH; pointer updates to the winner.
  - Winner's addr/size/wdata/wr latched; req_grant pulses in the grant cycle. The requester may drop req_valid afterwards.
- Beat count n = 1/2/4 from size. All mem_* outputs are registered.
- Byte k address = start + k, with carry across ADDR_W.
- Read timing:
  - RD_ISSUE drives mem_a = addr+k, mem_wr=0 for k=0..n-1, one per cycle, starting the cycle after grant.
  - Byte k is captured into bits [8k+7:8k] the following cycle.
  - After the last issue, go to RD_TAIL for one cycle to capture the final byte, then DONE.
  - DONE pulses resp_valid for one cycle with resp_rdata, then returns to IDLE.
  - Word read: grant T, issues T+1..T+4, resp_valid at T+6.
- Write timing:
  - WR_ISSUE drives mem_wr=1, mem_a = addr+k, mem_dout = wdata byte k, one byte per cycle.
  - DONE follows the last byte. Word write: grant T, writes T+1..T+4, resp_valid at T+5.
- Idle outputs: mem_wr=0 and mem_a=0 outside issue cycles. There is no back-to-back overlap, because the next grant happens only in IDLE.
- IO stall:
  - Applies when (addr+k)[17:16]==2'b11 and io_buffer_full=1.
  - Byte k is not issued (mem_wr=0, mem_a=0) and k holds; issue resumes the cycle after io_buffer_full falls.
  - Each IO byte is issued exactly once; no re-reads.
- Flush:
  - flush_in=1 during RD_ISSUE/RD_TAIL/DONE of a read: next state is IDLE, no resp_valid, remaining bytes not issued.
  - A write in progress ignores flush and completes with its ack.
  - No grant occurs in a flush cycle.
- rdy_in=0:
  - State, k, pointer and latched data are frozen; no issue (mem_wr=0, mem_a=0); grant and resp outputs are 0.
  - Exception: a byte issued in the previous cycle is still captured from mem_din.
  - Resumes exactly where it stopped.
- Simultaneous events:
  - flush_in with a same-cycle grant candidate: no grant.
  - Reset mid-transaction: immediate IDLE; no resp_valid ever appears for the aborted transaction.
- Width rules:
  - Unused upper resp_rdata bytes are 0.
  - Half/word addresses need not be aligned.

Test Plan:
- Word read ch0 at 0x100, RAM bytes 11,22,33,44 -> grant T; mem_a 0x100..0x103 at T+1..T+4; resp_valid[0] at T+6 with resp_rdata=0x44332211.
- Half write ch1 at 0x200, wdata=0xABCD1234 -> mem_wr=1 with (0x200,0x34), (0x201,0x12); resp_valid[1] at T+3; mem_wr=0 afterwards.
- Fixed priority: ch0 and ch1 requesting continuously -> only ch0 granted. Round-robin (PRIO_MODE=1) under the same stimulus -> grants alternate 0,1,0,1 starting at 0.
- Byte write to 0x30000 with io_buffer_full high for 3 cycles -> no mem_wr during the stall; a single mem_wr with mem_a=0x30000 the cycle after it falls; ack next cycle.
- flush_in asserted in the 2nd issue cycle of a word read -> no further addresses, no resp_valid, busy=0 next cycle. Flush during a word write -> all 4 bytes written and acked.
- rdy_in low for 2 cycles mid-word-read, and rst_in low mid-write:
  - rdy_in case -> issue sequence is contiguous apart from the freeze; data is still 0x44332211.
  - rst_in case -> all outputs 0 asynchronously; no ack.

Source files
------------

// File: rtl/mem_arbiter_nch.sv
// mem_arbiter_nch: serialises 1/2/4-byte requests from N_CH channels
// onto one byte-wide RAM/IO port (fixed or round-robin arbitration).
// Ports: clk_in, rst_in (async, active-low), rdy_in (freeze),
// flush_in (abort read), per-channel req_valid/wr/size/addr/wdata,
// req_grant/resp_valid pulses, resp_rdata, mem_din/dout/a/wr,
// io_buffer_full (stall IO bytes), busy (not IDLE).
module mem_arbiter_nch #(
  parameter int N_CH      = 2,
  parameter int ADDR_W    = 32,
  parameter int PRIO_MODE = 0
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   flush_in,
  input  logic [N_CH-1:0]        req_valid,
  input  logic [N_CH-1:0]        req_wr,
  input  logic [2*N_CH-1:0]      req_size,
  input  logic [ADDR_W*N_CH-1:0] req_addr,
  input  logic [32*N_CH-1:0]     req_wdata,
  output logic [N_CH-1:0]        req_grant,
  output logic [N_CH-1:0]        resp_valid,
  output logic [31:0]            resp_rdata,
  input  logic [7:0]             mem_din,
  output logic [7:0]             mem_dout,
  output logic [31:0]            mem_a,
  output logic                   mem_wr,
  input  logic                   io_buffer_full,
  output logic                   busy
);

  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_TAIL,
    WR_ISSUE,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        k_q, k_d;
  logic [CW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     ch_q, ch_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              iss_q, iss_d;
  logic [1:0]        iss_k_q, iss_k_d;
  logic              cap_q;
  logic [1:0]        cap_k_q;
  logic [31:0]       mem_a_q, mem_a_d;
  logic [7:0]        mem_dout_q, mem_dout_d;
  logic              mem_wr_q, mem_wr_d;
  logic [N_CH-1:0]   grant_q, grant_d;
  logic [N_CH-1:0]   resp_q, resp_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;

  logic              any_req;
  logic [CW-1:0]     win;
  logic [1:0]        last_k;
  logic [ADDR_W-1:0] cur_addr;
  logic [31:0]       cur_a32;
  logic              stall;

  assign req_grant  = grant_q;
  assign resp_valid = resp_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_a      = mem_a_q;
  assign mem_dout   = mem_dout_q;
  assign mem_wr     = mem_wr_q;
  assign busy       = (state_q != IDLE);

  assign any_req  = |req_valid;
  assign cur_addr = addr_q + ADDR_W'(k_q);
  assign cur_a32  = 32'(cur_addr);
  // Only the IO window is subject to the UART back-pressure.
  assign stall    = (cur_a32[17:16] == 2'b11) && io_buffer_full;

  // Winner search; RR starts one past the last winner.
  always_comb begin
    int idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (PRIO_MODE == 0) idx = i;
      else idx = (int'(ptr_q) + 1 + i) % N_CH;
      if (!found && req_valid[idx[CW-1:0]]) begin
        found = 1'b1;
        win   = idx[CW-1:0];
      end
    end
  end

  always_comb begin
    case (size_q)
      2'b00:   last_k = 2'd0;
      2'b01:   last_k = 2'd1;
      default: last_k = 2'd3;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    ptr_d        = ptr_q;
    ch_d         = ch_q;
    addr_d       = addr_q;
    size_d       = size_q;
    wdata_d      = wdata_q;
    wr_d         = wr_q;
    rdata_d      = rdata_q;
    iss_d        = 1'b0;
    iss_k_d      = k_q;
    mem_a_d      = '0;
    mem_dout_d   = '0;
    mem_wr_d     = 1'b0;
    grant_d      = '0;
    resp_d       = '0;
    resp_rdata_d = resp_rdata_q;

    // Capture runs even while frozen so an issued byte is never lost.
    if (cap_q) rdata_d[{cap_k_q, 3'b000} +: 8] = mem_din;

    if (rdy_in) begin
      unique case (state_q)
        IDLE: begin
          if (!flush_in && any_req) begin
            grant_d[win] = 1'b1;
            ptr_d   = win;
            ch_d    = win;
            addr_d  = req_addr[int'(win)*ADDR_W +: ADDR_W];
            size_d  = req_size[2*int'(win) +: 2];
            wdata_d = req_wdata[32*int'(win) +: 32];
            wr_d    = req_wr[win];
            k_d     = 2'd0;
            rdata_d = '0;
            state_d = req_wr[win] ? WR_ISSUE : RD_ISSUE;
          end
        end
        RD_ISSUE: begin
          if (flush_in) begin
            state_d = IDLE;
          end else if (!stall) begin
            mem_a_d = cur_a32;
            iss_d   = 1'b1;
            if (k_q == last_k) begin
              k_d     = 2'd0;
              state_d = RD_TAIL;
            end else begin
              k_d = k_q + 2'd1;
            end
          end
        end
        RD_TAIL: begin
          state_d = flush_in ? IDLE : DONE;
        end
        WR_ISSUE: begin
          if (!stall) begin
            mem_a_d    = cur_a32;
            mem_wr_d   = 1'b1;
            mem_dout_d = wdata_q[{k_q, 3'b000} +: 8];
            if (k_q == last_k) begin
              k_d     = 2'd0;
              state_d = DONE;
            end else begin
              k_d = k_q + 2'd1;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
          if (wr_q || !flush_in) begin
            resp_d[ch_q] = 1'b1;
            resp_rdata_d = wr_q ? 32'h0 : rdata_d;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= IDLE;
      k_q          <= '0;
      ptr_q        <= CW'(N_CH - 1);
      ch_q         <= '0;
      addr_q       <= '0;
      size_q       <= '0;
      wdata_q      <= '0;
      wr_q         <= 1'b0;
      rdata_q      <= '0;
      iss_q        <= 1'b0;
      iss_k_q      <= '0;
      cap_q        <= 1'b0;
      cap_k_q      <= '0;
      mem_a_q      <= '0;
      mem_dout_q   <= '0;
      mem_wr_q     <= 1'b0;
      grant_q      <= '0;
      resp_q       <= '0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      ptr_q        <= ptr_d;
      ch_q         <= ch_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      wdata_q      <= wdata_d;
      wr_q         <= wr_d;
      rdata_q      <= rdata_d;
      iss_q        <= iss_d;
      iss_k_q      <= iss_k_d;
      cap_q        <= iss_q;
      cap_k_q      <= iss_k_q;
      mem_a_q      <= mem_a_d;
      mem_dout_q   <= mem_dout_d;
      mem_wr_q     <= mem_wr_d;
      grant_q      <= grant_d;
      resp_q       <= resp_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter_nch.sv
// tb_mem_arbiter_nch: bench for mem_arbiter_nch (fixed + RR instances).
// Byte-RAM model, response/write scoreboards, vector table, corner cases.
`timescale 1ns/1ps
module tb_mem_arbiter_nch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rdy, flush, io_full;
  logic [1:0]  req_valid, req_wr;
  logic [3:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic [1:0]  grant, resp_valid;
  logic [31:0] resp_rdata, mem_a;
  logic [7:0]  mem_din, mem_dout;
  logic        mem_wr, busy;

  logic [1:0]  rr_valid, rr_wr, rr_grant, rr_resp;
  logic [3:0]  rr_size;
  logic [63:0] rr_addr, rr_wdata;
  logic [31:0] rr_rdata, rr_a;
  logic [7:0]  rr_din, rr_dout;
  logic        rr_mwr, rr_busy;

  assign rr_wr    = 2'b00;
  assign rr_size  = 4'b0000;
  assign rr_addr  = {32'h20, 32'h10};
  assign rr_wdata = '0;
  assign rr_din   = 8'h00;

  mem_arbiter_nch #(.N_CH(2), .ADDR_W(32), .PRIO_MODE(0)) dut (
    .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy), .flush_in(flush),
    .req_valid(req_valid), .req_wr(req_wr), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_grant(grant),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_full), .busy(busy)
  );

  mem_arbiter_nch #(.N_CH(2), .ADDR_W(32), .PRIO_MODE(1)) dut_rr (
    .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy), .flush_in(flush),
    .req_valid(rr_valid), .req_wr(rr_wr), .req_size(rr_size),
    .req_addr(rr_addr), .req_wdata(rr_wdata), .req_grant(rr_grant),
    .resp_valid(rr_resp), .resp_rdata(rr_rdata), .mem_din(rr_din),
    .mem_dout(rr_dout), .mem_a(rr_a), .mem_wr(rr_mwr),
    .io_buffer_full(io_full), .busy(rr_busy)
  );

  typedef struct {
    int          ch;
    logic [31:0] rdata;
    bit          chk;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [7:0]  d;
  } wexp_t;

  typedef struct {
    int          ch;
    bit          wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  exp_t  exp_q[$];
  wexp_t wq[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] ram [logic [31:0]];

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return a[7:0] ^ 8'h5A;
  endfunction

  always @(posedge clk) mem_din <= rd_byte(mem_a);

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  exp_t       mon_e;
  wexp_t      mon_w;
  logic [1:0] mon_oh;

  always @(negedge clk) begin
    if (rst_n && resp_valid != 2'b00) begin
      if (exp_q.size() == 0) begin
        check("resp_unexpected", 64'(resp_valid), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        mon_oh = '0;
        mon_oh[mon_e.ch] = 1'b1;
        check("resp_ch", 64'(resp_valid), 64'(mon_oh));
        if (mon_e.chk)
          check("resp_rdata", 64'(resp_rdata), 64'(mon_e.rdata));
      end
    end
    if (rst_n && mem_wr) begin
      ram[mem_a] = mem_dout;
      if (wq.size() == 0) begin
        check("wr_unexpected", 64'd1, 64'd0);
      end else begin
        mon_w = wq.pop_front();
        check("wr_addr", 64'(mem_a), 64'(mon_w.a));
        check("wr_data", 64'(mem_dout), 64'(mon_w.d));
      end
    end
  end

  task automatic start_req(input int ch, input bit wr,
                           input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] wd, input bit push_resp,
                           input logic [31:0] exp, input bit push_wr);
    int  nb;
    bit  got;
    req_wr[ch]            = wr;
    req_size[2*ch +: 2]   = sz;
    req_addr[32*ch +: 32] = a;
    req_wdata[32*ch +: 32] = wd;
    req_valid[ch]         = 1'b1;
    if (push_resp) exp_q.push_back('{ch, exp, !wr});
    if (wr && push_wr) begin
      nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
      for (int i = 0; i < nb; i++)
        wq.push_back('{32'(a + 32'(i)), wd[8*i +: 8]});
    end
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (grant[ch]) begin
        got = 1'b1;
        break;
      end
    end
    req_valid[ch] = 1'b0;
    if (!got) check("grant_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_grant(output logic [1:0] g);
    g = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (grant != 2'b00) begin
        g = grant;
        break;
      end
    end
    if (g == 2'b00) check("grant_wait_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check("idle_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  vec_t        vt [8];
  logic [31:0] ea [8];
  logic [1:0]  g;
  logic [1:0]  rr_exp [4];
  int          q, n;

  initial begin
    vt[0] = '{0, 1'b0, 2'b00, 32'h100, 32'h0, 32'h11};
    vt[1] = '{1, 1'b0, 2'b01, 32'h101, 32'h0, 32'h3322};
    vt[2] = '{0, 1'b1, 2'b10, 32'h400, 32'hDEADBEEF, 32'h0};
    vt[3] = '{1, 1'b0, 2'b10, 32'h402, 32'h0, 32'h5F5EDEAD};
    vt[4] = '{0, 1'b0, 2'b10, 32'hFFFFFFFE, 32'h0, 32'h5B5AA5A4};
    vt[5] = '{1, 1'b0, 2'b11, 32'h100, 32'h0, 32'h44332211};
    vt[6] = '{1, 1'b1, 2'b00, 32'h500, 32'h000000C3, 32'h0};
    vt[7] = '{0, 1'b0, 2'b01, 32'h4FF, 32'h0, 32'hC3A5};
    ea = '{32'h100, 32'h0, 32'h0, 32'h101, 32'h102, 32'h103, 32'h0, 32'h0};
    rr_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
    ram[32'h100] = 8'h11;
    ram[32'h101] = 8'h22;
    ram[32'h102] = 8'h33;
    ram[32'h103] = 8'h44;

    rst_n = 1'b1; rdy = 1'b1; flush = 1'b0; io_full = 1'b0;
    req_valid = '0; req_wr = '0; req_size = '0;
    req_addr = '0; req_wdata = '0; rr_valid = '0;
    #2 rst_n = 1'b0;
    #2;
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_resp", 64'(resp_valid), 64'd0);
    check("rst_rdata", 64'(resp_rdata), 64'd0);
    check("rst_mem_a", 64'(mem_a), 64'd0);
    check("rst_mem_wr_dout", 64'({mem_wr, mem_dout}), 64'd0);
    check("rst_busy", 64'({busy, rr_busy}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Word read timing
    start_req(0, 1'b0, 2'b10, 32'h100, 32'h0, 1'b1, 32'h44332211, 1'b1);
    check("A_grant", 64'(grant), 64'd1);
    check("A_busy", 64'(busy), 64'd1);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i <= 4) begin
        check("A_mem_a", 64'(mem_a), 64'(32'h100 + 32'(i - 1)));
        check("A_mem_wr", 64'(mem_wr), 64'd0);
      end
      if (i == 5) check("A_idle_a", 64'(mem_a), 64'd0);
      if (i < 6) begin
        check("A_no_resp", 64'(resp_valid), 64'd0);
      end else begin
        check("A_resp", 64'(resp_valid), 64'd1);
        check("A_rdata", 64'(resp_rdata), 64'h44332211);
        check("A_busy_end", 64'(busy), 64'd0);
      end
    end
    wait_idle();

    // Half write timing
    start_req(1, 1'b1, 2'b01, 32'h200, 32'hABCD1234, 1'b1, 32'h0, 1'b1);
    @(negedge clk);
    check("B_w0", 64'({mem_wr, mem_a, mem_dout}), 64'({1'b1, 32'h200, 8'h34}));
    @(negedge clk);
    check("B_w1", 64'({mem_wr, mem_a, mem_dout}), 64'({1'b1, 32'h201, 8'h12}));
    @(negedge clk);
    check("B_wr_off", 64'(mem_wr), 64'd0);
    check("B_resp", 64'(resp_valid), 64'd2);
    wait_idle();

    // Vector table
    for (int v = 0; v < 8; v++) begin
      start_req(vt[v].ch, vt[v].wr, vt[v].size, vt[v].addr,
                vt[v].wdata, 1'b1, vt[v].exp, 1'b1);
      wait_idle();
    end

    // Fixed priority under continuous contention
    req_wr = 2'b00; req_size = 4'b0000;
    req_addr = {32'h100, 32'h100};
    req_valid = 2'b11;
    for (int i = 0; i < 3; i++) begin
      wait_grant(g);
      check("C_fixed_grant", 64'(g), 64'd1);
      exp_q.push_back('{0, 32'h11, 1'b1});
    end
    req_valid = 2'b00;
    wait_idle();

    // IO stall on byte write
    io_full = 1'b1;
    start_req(0, 1'b1, 2'b00, 32'h30000, 32'h5A, 1'b1, 32'h0, 1'b1);
    @(negedge clk);
    check("D_stall1", 64'({mem_wr, mem_a}), 64'd0);
    @(negedge clk);
    check("D_stall2", 64'({mem_wr, mem_a}), 64'd0);
    io_full = 1'b0;
    @(negedge clk);
    check("D_issue", 64'({mem_wr, mem_a, mem_dout}), 64'({1'b1, 32'h30000, 8'h5A}));
    @(negedge clk);
    check("D_once", 64'(mem_wr), 64'd0);
    check("D_ack", 64'(resp_valid), 64'd1);
    wait_idle();

    // Flush in the 2nd issue cycle of a word read
    start_req(0, 1'b0, 2'b10, 32'h100, 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check("E_a0", 64'(mem_a), 64'h100);
    @(negedge clk);
    check("E_a1", 64'(mem_a), 64'h101);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("E_busy", 64'(busy), 64'd0);
    check("E_a_off", 64'(mem_a), 64'd0);
    q = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (mem_a != 32'h0 || resp_valid != 2'b00) q++;
    end
    check("E_quiet", 64'(q), 64'd0);

    // Flush ignored by a write
    start_req(1, 1'b1, 2'b10, 32'h600, 32'h01020304, 1'b1, 32'h0, 1'b1);
    flush = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 5) check("F_ack", 64'(resp_valid), 64'd2);
    end
    flush = 1'b0;
    wait_idle();

    // rdy_in freeze mid word read
    start_req(0, 1'b0, 2'b10, 32'h100, 32'h0, 1'b1, 32'h44332211, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check("G_mem_a", 64'(mem_a), 64'(ea[i-1]));
      if (i == 1) rdy = 1'b0;
      if (i == 3) rdy = 1'b1;
      if (i == 8) check("G_resp", 64'(resp_valid), 64'd1);
    end
    wait_idle();

    // Reset mid write
    start_req(1, 1'b1, 2'b10, 32'h700, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0);
    wq.push_back('{32'h700, 8'h0D});
    wq.push_back('{32'h701, 8'hF0});
    @(negedge clk);
    check("H_w0", 64'(mem_wr), 64'd1);
    @(negedge clk);
    check("H_w1", 64'(mem_a), 64'h701);
    #1 rst_n = 1'b0;
    #1;
    check("H_rst_outs", 64'({grant, resp_valid, mem_wr, busy, mem_dout}), 64'd0);
    check("H_rst_a", 64'(mem_a), 64'd0);
    check("H_rst_rdata", 64'(resp_rdata), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    q = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (resp_valid != 2'b00 || mem_wr) q++;
    end
    check("H_no_ack", 64'(q), 64'd0);

    // Round-robin instance under continuous contention
    rr_valid = 2'b11;
    n = 0;
    for (int i = 0; i < 60 && n < 4; i++) begin
      @(negedge clk);
      if (rr_grant != 2'b00) begin
        check("I_rr_grant", 64'(rr_grant), 64'(rr_exp[n]));
        n++;
      end
    end
    rr_valid = 2'b00;
    check("I_rr_count", 64'(n), 64'd4);
    repeat (8) @(negedge clk);

    check("sb_empty", 64'(exp_q.size() + wq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
